// File: rtl/serial_tx_fifo.sv
// Purpose : UART transmitter with input FIFO, runtime baud divisor, parity and stop-bit select.
// Latency : word pushed at edge N into an empty FIFO while idle -> tx falls after edge N+2.
// Backpr. : full stops new pushes (dropped word flagged by overflow); block holds off new frames.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   tx             serial line, idle high
//   data/new_data  word to queue and its write strobe (ignored while full)
//   full/overflow  FIFO full; one-cycle pulse when a push is dropped
//   level          FIFO occupancy
//   block          no new frame starts while high; a frame in progress completes
//   busy           frame active or FIFO non-empty
//   divisor        clk cycles per bit (values below 2 act as 2)
//   parity_mode    0/3 none, 1 even, 2 odd
//   stop2          0 one stop bit, 1 two stop bits
//   send_break     (only with SERIAL_TX_FIFO_BREAK_EN) hold tx low for DATA_BITS+3 bit periods
//
// Build option: define SERIAL_TX_FIFO_BREAK_EN to add the send_break input and BREAK state.

module serial_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CTR_SIZE   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        tx,
    input  logic [DATA_BITS-1:0]        data,
    input  logic                        new_data,
    output logic                        full,
    output logic                        overflow,
    input  logic                        block,
    output logic                        busy,
    input  logic [CTR_SIZE-1:0]         divisor,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop2,
`ifdef SERIAL_TX_FIFO_BREAK_EN
    input  logic                        send_break,
`endif
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    // Bit index / bit-period counter; wide enough for DATA_BITS+3 break periods (<= 12).
    localparam int BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
`ifdef SERIAL_TX_FIFO_BREAK_EN
        S_STOP,
        S_BREAK
`else
        S_STOP
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        level_d;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic [DATA_BITS-1:0] rd_dat;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign push   = new_data && !full;
    assign rd_dat = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap at FIFO_DEPTH.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            overflow_q <= new_data && full;
        end
    end

    assign level    = level_q;
    assign overflow = overflow_q;

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [DATA_BITS-1:0] sh_q;
    logic                 par_q;
    logic                 par_en_q;
    logic                 stop2_q;
    logic [CTR_SIZE-1:0]  period_q;
    logic [CTR_SIZE-1:0]  cnt_q;
    logic [BW-1:0]        bit_q;
    logic                 tx_q;
    logic                 busy_q;
    logic [CTR_SIZE-1:0]  div_eff;
    logic                 bit_end;

    assign div_eff = (divisor < CTR_SIZE'(2)) ? CTR_SIZE'(2) : divisor;
    // Full-width compare against the latched period: no truncation of the divisor.
    assign bit_end = (cnt_q == (period_q - CTR_SIZE'(1)));

`ifdef SERIAL_TX_FIFO_BREAK_EN
    // A break request wins over a waiting word.
    assign pop = (state_q == S_IDLE) && !empty && !block && !send_break;
`else
    assign pop = (state_q == S_IDLE) && !empty && !block;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            period_q <= CTR_SIZE'(2);
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            // busy follows the line: it stays up through the last tx stop cycle
            // (tx is one cycle behind state) and rises with the first push.
            busy_q <= (state_q != S_IDLE) || (level_d != '0);

            // tx is the registered image of the current state, one cycle behind it.
            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    cnt_q <= '0;
                    bit_q <= '0;
`ifdef SERIAL_TX_FIFO_BREAK_EN
                    if (send_break) begin
                        period_q <= div_eff;
                        state_q  <= S_BREAK;
                    end else
`endif
                    if (pop) begin
                        // Frame configuration is frozen here for the whole frame.
                        sh_q     <= rd_dat;
                        par_q    <= (parity_mode == 2'd2) ? ~(^rd_dat) : (^rd_dat);
                        par_en_q <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                        stop2_q  <= stop2;
                        period_q <= div_eff;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    tx_q <= sh_q[0];
                    if (bit_end) begin
                        sh_q <= {1'b0, sh_q[DATA_BITS-1:1]};
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    tx_q <= par_q;
                    if (bit_end) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        // bit_q counts stop bits already sent.
                        if (stop2_q && (bit_q == '0)) begin
                            bit_q <= BW'(1);
                        end else begin
                            bit_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                end
`ifdef SERIAL_TX_FIFO_BREAK_EN
                S_BREAK: begin
                    tx_q <= 1'b0;
                    if (bit_end) begin
                        if (bit_q == BW'(DATA_BITS + 2)) begin
                            bit_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                    end
                end
`endif
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase

            // Shared bit-period counter for every active state.
            if (state_q != S_IDLE) begin
                cnt_q <= bit_end ? '0 : (cnt_q + CTR_SIZE'(1));
            end
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: directed scenarios plus random batches, checked against
// a frame model built as a list of line levels per bit period.

module tb_serial_tx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx;
    logic [DB-1:0] data;
    logic          new_data;
    logic          full;
    logic          overflow;
    logic          block;
    logic          busy;
    logic [CW-1:0] divisor;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic [4:0]    level;
`ifdef SERIAL_TX_FIFO_BREAK_EN
    logic          send_break;
`endif

    int vectors     = 0;
    int miscompares = 0;

    serial_tx_fifo #(
        .DATA_BITS (DB),
        .FIFO_DEPTH(DEPTH),
        .CTR_SIZE  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (tx),
        .data       (data),
        .new_data   (new_data),
        .full       (full),
        .overflow   (overflow),
        .block      (block),
        .busy       (busy),
        .divisor    (divisor),
        .parity_mode(parity_mode),
        .stop2      (stop2),
`ifdef SERIAL_TX_FIFO_BREAK_EN
        .send_break (send_break),
`endif
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        data     = w;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    // Wait (bounded) for tx to go low; gap = high samples seen before it.
    task automatic wait_start(input string tag, output int gap);
        bit seen;
        seen = 1'b0;
        gap  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
            gap++;
        end
        chk({tag, "_start_seen"}, 32'(seen), 32'd1);
    endtask

    // Model: a frame is a list of line levels, each held for max(div,2) cycles.
    task automatic frame(input string tag, input logic [7:0] w, input int div, input int pm,
                         input bit s2, input int mid_div, input bit mid_block, input int exp_gap);
        int   gap;
        int   per;
        logic bits[$];
        wait_start(tag, gap);
        chk({tag, "_gap"}, 32'(gap), 32'(exp_gap));
        per = (div < 2) ? 2 : div;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(w[i]);
        if (pm == 1) bits.push_back(^w);
        else if (pm == 2) bits.push_back(~(^w));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int c = 0; c < per * bits.size(); c++) begin
            if (c != 0) @(negedge clk);
            if (c == per * 3) begin
                if (mid_div >= 0) divisor = CW'(mid_div);
                if (mid_block) block = 1'b1;
            end
            chk($sformatf("%s_tx_c%0d", tag, c), 32'(tx), 32'(bits[c / per]));
            if (c % per == 0) chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
        end
    endtask

    initial begin
        int         gap;
        int         ovf;
        int         lows;
        int         k;
        int         div;
        int         pm;
        bit         s2;
        logic [7:0] w;
        logic [7:0] q[$];

        rst = 1'b1; new_data = 1'b0; data = '0; block = 1'b0;
        divisor = CW'(4); parity_mode = 2'd0; stop2 = 1'b0;
`ifdef SERIAL_TX_FIFO_BREAK_EN
        send_break = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 8N1 frame, latency (gap 1 -> tx low two edges after push), busy drop.
        push_word(8'hA5);
        chk("a5_busy_rise", 32'(busy), 32'd1);
        chk("a5_level", 32'(level), 32'd1);
        frame("a5", 8'hA5, 4, 0, 1'b0, -1, 1'b0, 1);
        @(negedge clk);
        chk("a5_busy_end", 32'(busy), 32'd0);

        // Parity: odd then even on three ones.
        parity_mode = 2'd2;
        push_word(8'h07);
        frame("odd", 8'h07, 4, 2, 1'b0, -1, 1'b0, 1);
        @(negedge clk);
        parity_mode = 2'd1;
        push_word(8'h07);
        frame("even", 8'h07, 4, 1, 1'b0, -1, 1'b0, 1);
        @(negedge clk);

        // Two stop bits back to back; block raised mid-frame does not truncate it.
        parity_mode = 2'd0; stop2 = 1'b1; block = 1'b1;
        push_word(8'h3C); push_word(8'hC3); push_word(8'h5A);
        block = 1'b0;
        frame("s2a", 8'h3C, 4, 0, 1'b1, -1, 1'b0, 1);
        frame("s2b", 8'hC3, 4, 0, 1'b1, -1, 1'b1, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("blk_hold_tx", 32'(tx), 32'd1);
        end
        chk("blk_hold_level", 32'(level), 32'd1);
        chk("blk_hold_busy", 32'(busy), 32'd1);
        block = 1'b0;
        frame("s2c", 8'h5A, 4, 0, 1'b1, -1, 1'b0, 1);
        @(negedge clk);
        stop2 = 1'b0;

        // Fill under block: 17 pushes, one dropped.
        block = 1'b1; ovf = 0;
        q.delete();
        for (int i = 0; i < 17; i++) begin
            w = 8'($urandom_range(0, 255));
            if (i < 16) q.push_back(w);
            data = w; new_data = 1'b1;
            @(negedge clk);
            ovf += int'(overflow);
        end
        new_data = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ovf += int'(overflow);
        end
        chk("fill_ovf_pulses", 32'(ovf), 32'd1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_tx_idle", 32'(tx), 32'd1);
        block = 1'b0;
        for (int i = 0; i < 16; i++) frame($sformatf("fill%0d", i), q[i], 4, 0, 1'b0, -1, 1'b0, 1);
        @(negedge clk);
        chk("fill_busy_end", 32'(busy), 32'd0);
        chk("fill_level_end", 32'(level), 32'd0);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx === 1'b0) lows++;
        end
        chk("fill_no_17th", 32'(lows), 32'd0);

        // Divisor change mid-frame, then divisor 0 and 1 clamp to 2.
        block = 1'b1; divisor = CW'(4);
        push_word(8'h96); push_word(8'h69);
        block = 1'b0;
        frame("div4", 8'h96, 4, 0, 1'b0, 10, 1'b0, 1);
        frame("div10", 8'h69, 10, 0, 1'b0, -1, 1'b0, 1);
        @(negedge clk);
        divisor = CW'(0);
        push_word(8'hE1);
        frame("div0", 8'hE1, 0, 0, 1'b0, -1, 1'b0, 1);
        @(negedge clk);
        divisor = CW'(1);
        push_word(8'h1E);
        frame("div1", 8'h1E, 1, 0, 1'b0, -1, 1'b0, 1);
        @(negedge clk);

        // Reset in the middle of a data bit, with a second word queued.
        divisor = CW'(4); block = 1'b1;
        push_word(8'hF0); push_word(8'h0F);
        block = 1'b0;
        wait_start("rstmid", gap);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx", 32'(tx), 32'd1);
        chk("rstmid_level", 32'(level), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        push_word(8'hB4);
        frame("after_rst", 8'hB4, 4, 0, 1'b0, -1, 1'b0, 1);
        @(negedge clk);

        // Random batches with random frame configuration.
        for (int b = 0; b < 6; b++) begin
            div = $urandom_range(0, 6);
            pm  = $urandom_range(0, 3);
            s2  = 1'($urandom_range(0, 1));
            k   = $urandom_range(1, 4);
            divisor = CW'(div); parity_mode = 2'(pm); stop2 = s2; block = 1'b1;
            q.delete();
            for (int i = 0; i < k; i++) begin
                w = 8'($urandom_range(0, 255));
                q.push_back(w);
                push_word(w);
            end
            block = 1'b0;
            for (int i = 0; i < k; i++)
                frame($sformatf("rnd%0d_%0d", b, i), q[i], div, pm, s2, -1, 1'b0, 1);
            @(negedge clk);
            chk($sformatf("rnd%0d_busy_end", b), 32'(busy), 32'd0);
        end

`ifdef SERIAL_TX_FIFO_BREAK_EN
        // Break takes priority over a queued word and lasts (DATA_BITS+3)*4 = 44 cycles.
        divisor = CW'(4); parity_mode = 2'd0; stop2 = 1'b0; block = 1'b1;
        push_word(8'h55);
        send_break = 1'b1; block = 1'b0;
        @(negedge clk);
        send_break = 1'b0;
        wait_start("brk", gap);
        chk("brk_gap", 32'(gap), 32'd0);
        lows = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b0) break;
            lows++;
            if (lows == 20) chk("brk_busy", 32'(busy), 32'd1);
        end
        chk("brk_len", 32'(lows), 32'd44);
        frame("brk_frame", 8'h55, 4, 0, 1'b0, -1, 1'b0, 0);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 serial transmitter. Adds a configurable data width, runtime baud divisor, runtime parity and stop-bit selection, and an input FIFO so producers can burst bytes without waiting on busy. Sits between on-chip producers (debug and status streams) and the board TX pin. The existing block/busy flow-control contract is kept.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
FIFO_DEPTH, 16, input FIFO entries, power of 2, at least 2
CTR_SIZE, 16, width of baud divisor and bit counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
tx  out  1  serial line, idle high
data  in  DATA_BITS  word to queue
new_data  in  1  write strobe; data is pushed when !full
full  out  1  FIFO full; new_data is ignored while high
overflow  out  1  one-cycle pulse when new_data is asserted while full
block  in  1  high: no new frame starts; the frame in progress completes
busy  out  1  high while a frame is active or the FIFO is non-empty
divisor  in  CTR_SIZE  clk cycles per bit; values below 2 are treated as 2
parity_mode  in  2  0 none, 1 even, 2 odd, 3 none
stop2  in  1  0: one stop bit, 1: two stop bits
level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: tx=1, busy=0, full=0, overflow=0, level=0; FIFO emptied; FSM to IDLE. Reset mid-frame aborts the frame and drives tx high on the next cycle.
- FIFO push: on new_data && !full, store the word; level increments at the next edge.
- FIFO pop: performed by the FSM only. Simultaneous push and pop leave level unchanged. A push into an empty FIFO is visible to the FSM one cycle later; there is no bypass.
- Pointers wrap modulo FIFO_DEPTH. full = (level == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty and block=0: pop the head into the shift register, latch divisor, parity_mode and stop2, then go to START.
  - Config changes mid-frame have no effect.
- START: tx=0 for one bit period, then DATA.
- DATA:
  - Send the LSB first, DATA_BITS bits.
  - After the last bit, go to PARITY if the latched parity_mode is 1 or 2, else STOP.
- PARITY:
  - Even mode: tx = XOR of the data bits.
  - Odd mode: tx = inverted XOR of the data bits.
  - Lasts one bit period.
- STOP:
  - tx=1 for one bit period, or two if stop2 was latched.
  - Then go to IDLE.
- Back-to-back frames: after STOP, if the FIFO is non-empty and block=0, the next start bit begins one cycle after STOP ends, so the line sees one extra clk of idle.
- Bit period: exactly max(divisor,2) clk cycles. The counter counts 0..period-1; the compare is full CTR_SIZE width with no truncation.
- Latency: new_data at edge N into an empty FIFO while idle → tx falls after edge N+2.
- busy is registered. It is high from the cycle after the first push until the cycle after the STOP of the last queued frame.
- block asserted during a frame does not truncate it. FIFO contents are retained while blocked, and pushes continue to be accepted.
- overflow is registered; the dropped word is lost and the FIFO is unchanged.

Optional Feature:
Macro SERIAL_TX_FIFO_BREAK_EN.
- When defined:
  - Adds input send_break (1 bit).
  - Sampled only in IDLE. When send_break=1, the FSM enters a BREAK state that holds tx=0 for (DATA_BITS+3) bit periods, then returns to IDLE.
  - busy is high during BREAK.
  - send_break takes priority over a pending FIFO word. It is not gated by block.
- When undefined:
  - No port and no state.
  - tx never goes low outside START/DATA/PARITY.

Test Plan:
- divisor=4, parity 0, stop2=0, push 0xA5 → tx: low 4, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4; busy falls afterwards; tx falls 2 cycles after new_data.
- parity_mode=2, push 0x07 (three ones) → parity bit 0; parity_mode=1 → parity bit 1; stop2=1 → 8 high cycles before the next start bit.
- FIFO_DEPTH=16, block=1, push 17 words → full after 16, overflow pulses once, level=16; release block → 16 frames in order, byte 17 absent.
- Change divisor from 4 to 10 mid-frame → current frame stays at 4 cycles/bit; next frame uses 10; divisor=0 → 2 cycles/bit.
- Assert rst in the middle of a DATA bit → tx=1 the next cycle, level=0, busy=0; a new push then transmits normally.
- With SERIAL_TX_FIFO_BREAK_EN, divisor=4, DATA_BITS=8, FIFO holding 0x55: pulse send_break in IDLE → tx low 44 cycles, then 0x55 frame follows.
